instruction_fetch: RTL and testbench

- Responder side of the Control_Unit instruction interface: Control_Unit drives `pc`, this block returns the instruction stored at `pc`.
- Holds a host-loadable instruction memory.
- Re-fetches whenever `pc` changes and qualifies the output with `instr_valid`.
- Sits between the host/test loader and Control_Unit, replacing the testbench-driven `instruction` bus.

---
 rtl/accel_pkg.sv | 40 ++++
 rtl/instruction_fetch_if.sv | 41 ++++
 rtl/instruction_memory.sv | 44 ++++
 rtl/instruction_fetch.sv | 161 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator definitions for the instruction fetch path.
// Contents:
//   - opcode field width and opcode encodings
//   - instruction word field widths and the derived InstructionSize
//   - fetch FSM state encoding
//   - a saturating 16-bit increment helper for the fetch counter
package accel_pkg;

    localparam int OpcodeWidth   = 3;
    localparam int DramAddrWidth = 8;
    localparam int UbAddrWidth   = 10;
    localparam int ColWidth      = 4;
    localparam int RowWidth      = 4;

    // {opcode, dram addr, ub addr, col, row}
    localparam int InstructionSize =
        OpcodeWidth + DramAddrWidth + UbAddrWidth + ColWidth + RowWidth;

    typedef enum logic [OpcodeWidth-1:0] {
        NOP      = 3'b000,
        MVIN     = 3'b001,
        MVOUT    = 3'b010,
        QUANTIZE = 3'b011,
        HALT     = 3'b111
    } opcode_t;

    // State literals carry an ST_ prefix so they cannot collide with the
    // HALT opcode literal in this package's namespace.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the host/Control_Unit side and the instruction fetch block.
// Signals:
//   EN           run enable (0 = load mode, 1 = fetch mode)
//   load_en      host write strobe
//   load_addr    host write address
//   load_data    host write data
//   pc           program counter from Control_Unit
//   instruction  fetched instruction
//   instr_valid  instruction corresponds to the current pc
//   halted       HALT opcode reached
//   pc_fault     pc beyond instruction memory depth
//   fetch_count  saturating count of issued instructions
// Modports: master = host/Control_Unit side, slave = fetch block.
interface instruction_fetch_if #(
    parameter int INSTR_WIDTH   = 29,
    parameter int IM_ADDR_WIDTH = 32,
    parameter int IM_DEPTH_LOG2 = 6
) ();

    logic                     EN;
    logic                     load_en;
    logic [IM_DEPTH_LOG2-1:0] load_addr;
    logic [INSTR_WIDTH-1:0]   load_data;
    logic [IM_ADDR_WIDTH-1:0] pc;
    logic [INSTR_WIDTH-1:0]   instruction;
    logic                     instr_valid;
    logic                     halted;
    logic                     pc_fault;
    logic [15:0]              fetch_count;

    modport master (
        output EN, load_en, load_addr, load_data, pc,
        input  instruction, instr_valid, halted, pc_fault, fetch_count
    );

    modport slave (
        input  EN, load_en, load_addr, load_data, pc,
        output instruction, instr_valid, halted, pc_fault, fetch_count
    );

endinterface

// File: rtl/instruction_memory.sv
// Simple dual-port instruction RAM: one synchronous write port and one
// synchronous read port with 1-cycle latency. No reset; contents persist
// across block resets.
// Ports:
//   clk        clock, rising edge
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe; read data only updates when asserted
//   rd_addr_i  read address
//   rd_data_o  registered read data
module instruction_memory #(
    parameter int INSTR_WIDTH   = 29,
    parameter int IM_DEPTH_LOG2 = 6
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [IM_DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [INSTR_WIDTH-1:0]   wr_data_i,
    input  logic                     rd_en_i,
    input  logic [IM_DEPTH_LOG2-1:0] rd_addr_i,
    output logic [INSTR_WIDTH-1:0]   rd_data_o
);

    localparam int Depth = 1 << IM_DEPTH_LOG2;

    logic [INSTR_WIDTH-1:0] mem_q [Depth];
    logic [INSTR_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch responder for Control_Unit. Holds a host-loadable
// instruction memory; while EN=1 it fetches the word at pc and qualifies
// it with instr_valid, re-fetching whenever pc changes.
// Ports:
//   CLK       clock, rising edge
//   SYNC_RST  synchronous active-high reset (memory contents untouched)
//   bus       instruction_fetch_if slave modport (EN, load, pc, outputs)
module instruction_fetch
    import accel_pkg::*;
#(
    parameter int INSTR_WIDTH   = 29,
    parameter int IM_ADDR_WIDTH = 32,
    parameter int IM_DEPTH_LOG2 = 6
) (
    input  logic                CLK,
    input  logic                SYNC_RST,
    instruction_fetch_if.slave  bus
);

    fetch_state_t             state_q, state_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     valid_q, valid_d;
    logic                     halted_q, halted_d;
    logic                     fault_q, fault_d;
    logic [15:0]              count_q, count_d;
    logic [IM_ADDR_WIDTH-1:0] pc_last_q, pc_last_d;

    logic                     mem_we;
    logic                     mem_re;
    logic [INSTR_WIDTH-1:0]   mem_rdata;
    logic                     pc_in_range;
    opcode_t                  rd_opcode;

    // Range check on the full pc width: any set bit above the memory
    // index is a fault, never a silent wrap onto a low address.
    assign pc_in_range = (bus.pc >> IM_DEPTH_LOG2) == '0;
    assign rd_opcode   = opcode_t'(mem_rdata[INSTR_WIDTH-1 -: OpcodeWidth]);

    instruction_memory #(
        .INSTR_WIDTH   (INSTR_WIDTH),
        .IM_DEPTH_LOG2 (IM_DEPTH_LOG2)
    ) u_mem (
        .clk       (CLK),
        .wr_en_i   (mem_we),
        .wr_addr_i (bus.load_addr),
        .wr_data_i (bus.load_data),
        .rd_en_i   (mem_re),
        .rd_addr_i (bus.pc[IM_DEPTH_LOG2-1:0]),
        .rd_data_o (mem_rdata)
    );

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
            count_q   <= '0;
            pc_last_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
            pc_last_q <= pc_last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        fault_d   = fault_q;
        count_d   = count_q;
        pc_last_d = pc_last_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (!bus.EN) begin
                    // Memory is writable only here, so fetch mode never
                    // sees a word change underneath it.
                    mem_we = bus.load_en;
                end else if (!pc_in_range) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    mem_re    = 1'b1;
                    pc_last_d = bus.pc;
                    state_d   = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (!bus.EN) begin
                    // In-flight read is discarded; instruction keeps its
                    // old value but is no longer qualified.
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    // The captured word belongs to pc_last even if pc has
                    // already moved; VALID will notice and re-fetch.
                    instr_d = mem_rdata;
                    if (rd_opcode == HALT) begin
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        valid_d = 1'b1;
                        count_d = sat_inc16(count_q);
                        state_d = ST_VALID;
                    end
                end
            end

            ST_VALID: begin
                if (!bus.EN) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (bus.pc != pc_last_q) begin
                    valid_d = 1'b0;
                    if (!pc_in_range) begin
                        fault_d = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        mem_re    = 1'b1;
                        pc_last_d = bus.pc;
                        state_d   = ST_FETCH;
                    end
                end
            end

            ST_HALT: begin
                valid_d = 1'b0;
                if (!bus.EN) begin
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.pc_fault    = fault_q;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import accel_pkg::*;

    localparam int IW = 29;
    localparam int AW = 32;
    localparam int DL = 6;

    typedef struct {
        logic [IW-1:0] instr;
        logic [15:0]   count;
    } exp_t;

    logic CLK = 1'b0;
    logic SYNC_RST;

    instruction_fetch_if #(.INSTR_WIDTH(IW), .IM_ADDR_WIDTH(AW), .IM_DEPTH_LOG2(DL)) bus ();

    instruction_fetch #(.INSTR_WIDTH(IW), .IM_ADDR_WIDTH(AW), .IM_DEPTH_LOG2(DL)) dut (
        .CLK      (CLK),
        .SYNC_RST (SYNC_RST),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    // Hand-built instruction words: {opcode, dram, ub, col, row}
    localparam logic [IW-1:0] W_MVIN  = {3'b001, 8'h23, 10'h0E0, 4'd3, 4'd3};
    localparam logic [IW-1:0] W_MVOUT = {3'b010, 8'h45, 10'h1A0, 4'd2, 4'd1};
    localparam logic [IW-1:0] W_HALT  = {3'b111, 8'h00, 10'h000, 4'd0, 4'd0};
    localparam logic [IW-1:0] W_NOP   = {3'b000, 8'h5A, 10'h155, 4'd7, 4'd9};
    localparam logic [IW-1:0] W_QUANT = {3'b011, 8'hFF, 10'h3FF, 4'd15, 4'd14};

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [IW-1:0] w, input logic [15:0] c);
        exp_t e;
        e.instr = w;
        e.count = c;
        sb_q.push_back(e);
    endtask

    task automatic load(input logic [DL-1:0] a, input logic [IW-1:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        step();
        bus.load_en   = 1'b0;
    endtask

    // Monitor: each new qualified instruction must match the oldest
    // expected entry.
    logic prev_valid = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (bus.instr_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got instruction %0h with empty queue", bus.instruction);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_instruction", 32'(bus.instruction), 32'(e.instr));
                check("sb_fetch_count", 32'(bus.fetch_count), 32'(e.count));
            end
        end
        prev_valid = bus.instr_valid;
    end

    initial begin
        SYNC_RST      = 1'b1;
        bus.EN        = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.pc        = '0;
        step();
        step();
        check("rst_instruction", 32'(bus.instruction), 32'h0);
        check("rst_valid",       32'(bus.instr_valid), 32'h0);
        check("rst_halted",      32'(bus.halted), 32'h0);
        check("rst_fault",       32'(bus.pc_fault), 32'h0);
        check("rst_count",       32'(bus.fetch_count), 32'h0);
        SYNC_RST = 1'b0;

        load(6'd0,  W_MVIN);
        load(6'd1,  W_MVOUT);
        load(6'd2,  W_HALT);
        load(6'd3,  W_NOP);
        load(6'd63, W_QUANT);

        // First fetch: exactly 2 edges to valid
        bus.pc = 32'd0;
        bus.EN = 1'b1;
        push(W_MVIN, 16'd1);
        step();
        check("lat_edge1_valid", 32'(bus.instr_valid), 32'h0);
        step();
        check("lat_edge2_valid", 32'(bus.instr_valid), 32'h1);
        step();
        step();
        check("hold_valid", 32'(bus.instr_valid), 32'h1);
        check("hold_instr", 32'(bus.instruction), 32'(W_MVIN));

        // pc change in VALID
        bus.pc = 32'd1;
        push(W_MVOUT, 16'd2);
        step();
        check("pcchg_drop", 32'(bus.instr_valid), 32'h0);
        step();
        check("pcchg_valid", 32'(bus.instr_valid), 32'h1);

        // NOP is a normal instruction; top address is in range
        bus.pc = 32'd3;
        push(W_NOP, 16'd3);
        step();
        step();
        check("nop_valid", 32'(bus.instr_valid), 32'h1);
        bus.pc = 32'd63;
        push(W_QUANT, 16'd4);
        step();
        step();
        check("pc63_valid", 32'(bus.instr_valid), 32'h1);

        // HALT opcode
        bus.pc = 32'd2;
        step();
        step();
        check("halt_halted", 32'(bus.halted), 32'h1);
        check("halt_valid",  32'(bus.instr_valid), 32'h0);
        check("halt_count",  32'(bus.fetch_count), 32'd4);
        step();
        check("halt_hold", 32'(bus.halted), 32'h1);
        bus.EN = 1'b0;
        step();
        check("halt_clear", 32'(bus.halted), 32'h0);

        // Out-of-range pc
        bus.pc = 32'd64;
        bus.EN = 1'b1;
        step();
        check("fault64_set",   32'(bus.pc_fault), 32'h1);
        check("fault64_valid", 32'(bus.instr_valid), 32'h0);
        step();
        check("fault64_valid2", 32'(bus.instr_valid), 32'h0);
        bus.EN = 1'b0;
        step();
        check("fault64_clear", 32'(bus.pc_fault), 32'h0);

        // High pc bit must fault, not alias to address 0
        bus.pc = 32'h8000_0000;
        bus.EN = 1'b1;
        step();
        check("faulthi_set", 32'(bus.pc_fault), 32'h1);
        bus.EN = 1'b0;
        step();
        check("faulthi_clear", 32'(bus.pc_fault), 32'h0);

        // Loads during fetch mode are ignored
        bus.pc        = 32'd0;
        bus.EN        = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 6'd0;
        bus.load_data = '0;
        push(W_MVIN, 16'd5);
        step();
        step();
        step();
        bus.load_en = 1'b0;
        check("ldign_instr", 32'(bus.instruction), 32'(W_MVIN));

        // EN=0 in VALID drops valid, instruction unchanged
        bus.EN = 1'b0;
        step();
        check("endrop_valid", 32'(bus.instr_valid), 32'h0);
        check("endrop_instr", 32'(bus.instruction), 32'(W_MVIN));

        // pc moves while in FETCH: old capture completes, then re-fetch
        bus.pc = 32'd0;
        bus.EN = 1'b1;
        push(W_MVIN, 16'd6);
        push(W_MVOUT, 16'd7);
        step();
        bus.pc = 32'd1;
        step();
        check("midfetch_valid", 32'(bus.instr_valid), 32'h1);
        step();
        check("midfetch_drop", 32'(bus.instr_valid), 32'h0);
        step();
        check("midfetch_revalid", 32'(bus.instr_valid), 32'h1);

        // Reset during FETCH
        bus.pc = 32'd0;
        step();
        SYNC_RST = 1'b1;
        step();
        check("midrst_instruction", 32'(bus.instruction), 32'h0);
        check("midrst_valid",       32'(bus.instr_valid), 32'h0);
        check("midrst_count",       32'(bus.fetch_count), 32'h0);
        check("midrst_halted",      32'(bus.halted), 32'h0);
        SYNC_RST = 1'b0;
        push(W_MVIN, 16'd1);
        step();
        step();
        check("postrst_valid", 32'(bus.instr_valid), 32'h1);
        step();

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
